c2h_tlb_cfg_regs: RTL and testbench

AXI4-Lite register file holding the cluster-to-host (C2H) TLB entries. It sits directly downstream of the cluster crossbar's `axilite_master` port, which covers the C2H TLB config window at cluster base + 0x0040_0000 .. +0x0050_0000. It accepts single-beat 32-bit reads and writes and drives the entry table consumed by the C2H address-translation stage. All entries reset to invalid.

---
 rtl/c2h_tlb_cfg_regs.sv | 198 +++++++++++++++++++
 tb/tb_c2h_tlb_cfg_regs.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2h_tlb_cfg_regs.sv
// AXI4-Lite register file holding the C2H TLB entry table.
// Each entry occupies eight 32-bit words: first, last and base (64 bits each),
// a flags word (valid, ro) and a reserved word. Only addr[19:0] is decoded.
module c2h_tlb_cfg_regs #(
  parameter int unsigned NB_ENTRIES     = 8,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  localparam int unsigned IDX_W = (NB_ENTRIES > 1) ? $clog2(NB_ENTRIES) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // Write address / data / response
  input  logic [AXI_ADDR_WIDTH-1:0]  aw_addr_i,
  input  logic                       aw_valid_i,
  output logic                       aw_ready_o,
  input  logic [31:0]                w_data_i,
  input  logic [3:0]                 w_strb_i,
  input  logic                       w_valid_i,
  output logic                       w_ready_o,
  output logic [1:0]                 b_resp_o,
  output logic                       b_valid_o,
  input  logic                       b_ready_i,
  // Read address / data
  input  logic [AXI_ADDR_WIDTH-1:0]  ar_addr_i,
  input  logic                       ar_valid_i,
  output logic                       ar_ready_o,
  output logic [31:0]                r_data_o,
  output logic [1:0]                 r_resp_o,
  output logic                       r_valid_o,
  input  logic                       r_ready_i,
  // Entry table
  output logic [NB_ENTRIES*64-1:0]   entry_first_o,
  output logic [NB_ENTRIES*64-1:0]   entry_last_o,
  output logic [NB_ENTRIES*64-1:0]   entry_base_o,
  output logic [NB_ENTRIES-1:0]      entry_valid_o,
  output logic [NB_ENTRIES-1:0]      entry_ro_o,
  output logic                       cfg_update_o,
  output logic [IDX_W-1:0]           cfg_update_idx_o
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic [NB_ENTRIES*64-1:0] first_q, last_q, base_q;
  logic [NB_ENTRIES-1:0]    valid_q, ro_q;

  logic             b_valid_q;
  logic [1:0]       b_resp_q;
  logic             r_valid_q;
  logic [1:0]       r_resp_q;
  logic [31:0]      r_data_q;
  logic             cfg_update_q;
  logic [IDX_W-1:0] cfg_update_idx_q;

  logic [14:0] wr_idx, rd_idx;
  logic [2:0]  wr_word, rd_word;
  logic        wr_in_range, rd_in_range;
  logic        wr_fire, rd_fire;
  logic [31:0] rd_data;

  // Address bits outside [19:2] carry no meaning for this window.
  logic unused_addr;
  assign unused_addr = ^{aw_addr_i[AXI_ADDR_WIDTH-1:20], aw_addr_i[1:0],
                         ar_addr_i[AXI_ADDR_WIDTH-1:20], ar_addr_i[1:0]};

  assign wr_idx      = aw_addr_i[19:5];
  assign wr_word     = aw_addr_i[4:2];
  assign rd_idx      = ar_addr_i[19:5];
  assign rd_word     = ar_addr_i[4:2];
  assign wr_in_range = 32'(wr_idx) < NB_ENTRIES;
  assign rd_in_range = 32'(rd_idx) < NB_ENTRIES;

  // AW and W are only ever taken together, and only when the B slot is free.
  assign aw_ready_o = aw_valid_i & w_valid_i & (~b_valid_q | b_ready_i);
  assign w_ready_o  = aw_ready_o;
  assign wr_fire    = aw_ready_o;
  assign ar_ready_o = ~r_valid_q | r_ready_i;
  assign rd_fire    = ar_valid_i & ar_ready_o;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Entry table update on an accepted in-range write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_q <= '0;
      last_q  <= '0;
      base_q  <= '0;
      valid_q <= '0;
      ro_q    <= '0;
    end else if (wr_fire && wr_in_range) begin
      for (int e = 0; e < int'(NB_ENTRIES); e++) begin
        if (wr_idx == 15'(e)) begin
          case (wr_word)
            3'd0: first_q[e*64 +: 32]      <= merge_bytes(first_q[e*64 +: 32], w_data_i, w_strb_i);
            3'd1: first_q[e*64 + 32 +: 32] <= merge_bytes(first_q[e*64 + 32 +: 32], w_data_i,
                                                          w_strb_i);
            3'd2: last_q[e*64 +: 32]       <= merge_bytes(last_q[e*64 +: 32], w_data_i, w_strb_i);
            3'd3: last_q[e*64 + 32 +: 32]  <= merge_bytes(last_q[e*64 + 32 +: 32], w_data_i,
                                                          w_strb_i);
            3'd4: base_q[e*64 +: 32]       <= merge_bytes(base_q[e*64 +: 32], w_data_i, w_strb_i);
            3'd5: base_q[e*64 + 32 +: 32]  <= merge_bytes(base_q[e*64 + 32 +: 32], w_data_i,
                                                          w_strb_i);
            3'd6: begin
              // Flags live entirely in byte lane 0.
              if (w_strb_i[0]) begin
                valid_q[e] <= w_data_i[0];
                ro_q[e]    <= w_data_i[1];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_data = '0;
    for (int e = 0; e < int'(NB_ENTRIES); e++) begin
      if (rd_in_range && rd_idx == 15'(e)) begin
        case (rd_word)
          3'd0: rd_data = first_q[e*64 +: 32];
          3'd1: rd_data = first_q[e*64 + 32 +: 32];
          3'd2: rd_data = last_q[e*64 +: 32];
          3'd3: rd_data = last_q[e*64 + 32 +: 32];
          3'd4: rd_data = base_q[e*64 +: 32];
          3'd5: rd_data = base_q[e*64 + 32 +: 32];
          3'd6: rd_data = {30'b0, ro_q[e], valid_q[e]};
          default: rd_data = '0;
        endcase
      end
    end
  end

  // Write response slot: loaded on accept, cleared when taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
    end else if (wr_fire) begin
      b_valid_q <= 1'b1;
      b_resp_q  <= wr_in_range ? RespOkay : RespSlverr;
    end else if (b_ready_i) begin
      b_valid_q <= 1'b0;
    end
  end

  // Read response slot: data captured in the accept cycle, held until taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_resp_q  <= RespOkay;
      r_data_q  <= '0;
    end else if (rd_fire) begin
      r_valid_q <= 1'b1;
      r_resp_q  <= rd_in_range ? RespOkay : RespSlverr;
      r_data_q  <= rd_data;
    end else if (r_ready_i) begin
      r_valid_q <= 1'b0;
    end
  end

  // One-cycle notification after any in-range flags write, even with strobe 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_update_q     <= 1'b0;
      cfg_update_idx_q <= '0;
    end else begin
      cfg_update_q <= wr_fire && wr_in_range && (wr_word == 3'd6);
      if (wr_fire && wr_in_range && (wr_word == 3'd6)) begin
        cfg_update_idx_q <= wr_idx[IDX_W-1:0];
      end
    end
  end

  assign b_valid_o        = b_valid_q;
  assign b_resp_o         = b_resp_q;
  assign r_valid_o        = r_valid_q;
  assign r_resp_o         = r_resp_q;
  assign r_data_o         = r_data_q;
  assign cfg_update_o     = cfg_update_q;
  assign cfg_update_idx_o = cfg_update_idx_q;
  assign entry_first_o    = first_q;
  assign entry_last_o     = last_q;
  assign entry_base_o     = base_q;
  assign entry_valid_o    = valid_q;
  assign entry_ro_o       = ro_q;

endmodule

// File: tb/tb_c2h_tlb_cfg_regs.sv
// Self-checking bench for c2h_tlb_cfg_regs. The reference model keeps each
// entry as an array of eight 32-bit words and derives the entry outputs from it.
module tb_c2h_tlb_cfg_regs;

  localparam int NB = 8;
  localparam int IW = 3;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [31:0]          aw_addr_i, ar_addr_i, w_data_i;
  logic [3:0]           w_strb_i;
  logic                 aw_valid_i, w_valid_i, b_ready_i, ar_valid_i, r_ready_i;
  logic                 aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o;
  logic [1:0]           b_resp_o, r_resp_o;
  logic [31:0]          r_data_o;
  logic [NB*64-1:0]     entry_first_o, entry_last_o, entry_base_o;
  logic [NB-1:0]        entry_valid_o, entry_ro_o;
  logic                 cfg_update_o;
  logic [IW-1:0]        cfg_update_idx_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_w [NB][8];

  c2h_tlb_cfg_regs #(.NB_ENTRIES(NB), .AXI_ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .entry_first_o(entry_first_o), .entry_last_o(entry_last_o), .entry_base_o(entry_base_o),
    .entry_valid_o(entry_valid_o), .entry_ro_o(entry_ro_o),
    .cfg_update_o(cfg_update_o), .cfg_update_idx_o(cfg_update_idx_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int e = 0; e < NB; e++)
      for (int k = 0; k < 8; k++) m_w[e][k] = 32'h0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
    int idx, wd;
    idx = int'(a[19:5]);
    wd  = int'(a[4:2]);
    if (idx >= NB) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      for (int b = 0; b < 4; b++)
        if (s[b]) m_w[idx][wd][b*8 +: 8] = d[b*8 +: 8];
      if (wd == 6) m_w[idx][wd] = m_w[idx][wd] & 32'h3;
      if (wd == 7) m_w[idx][wd] = 32'h0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'(a[19:5]);
    if (idx >= NB) return 32'h0;
    return m_w[idx][int'(a[4:2])];
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return (int'(a[19:5]) >= NB) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [NB*64-1:0] exp_pair(input int lo);
    logic [NB*64-1:0] r;
    for (int e = 0; e < NB; e++) r[e*64 +: 64] = {m_w[e][lo+1], m_w[e][lo]};
    return r;
  endfunction

  function automatic logic [NB-1:0] exp_flag(input int bitpos);
    logic [NB-1:0] r;
    for (int e = 0; e < NB; e++) r[e] = m_w[e][6][bitpos];
    return r;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic apply_reset();
    aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0; b_ready_i = 0; r_ready_i = 0;
    aw_addr_i = 0; ar_addr_i = 0; w_data_i = 0; w_strb_i = 0;
    rst_i = 1;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    model_reset();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic bv, output logic upd,
                          output logic [IW-1:0] upd_idx, output logic upd_after,
                          output logic tmo);
    int cnt = 0;
    b_ready_i = 0;
    aw_addr_i = a; w_data_i = d; w_strb_i = s;
    aw_valid_i = 1; w_valid_i = 1;
    #1;
    while (!aw_ready_o && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    tmo = (cnt >= 20);
    @(posedge clk); #1;
    aw_valid_i = 0; w_valid_i = 0;
    bv = b_valid_o; resp = b_resp_o; upd = cfg_update_o; upd_idx = cfg_update_idx_o;
    b_ready_i = 1;
    @(posedge clk); #1;
    upd_after = cfg_update_o;
    b_ready_i = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d2,
                         output logic [1:0] resp, output logic rv, output logic tmo);
    int cnt = 0;
    r_ready_i = 0;
    ar_addr_i = a; ar_valid_i = 1;
    #1;
    while (!ar_ready_o && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    tmo = (cnt >= 20);
    @(posedge clk); #1;
    ar_valid_i = 0;
    rv = r_valid_o; d1 = r_data_o; resp = r_resp_o;
    @(posedge clk); #1;
    d2 = r_data_o;
    r_ready_i = 1;
    @(posedge clk); #1;
    r_ready_i = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d1, d2; logic [1:0] rs; logic rv, tmo;
    apply_reset();
    tests++;
    if ({aw_ready_o, w_ready_o, b_valid_o, r_valid_o, cfg_update_o} !== 5'b0 ||
        ar_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ctrl: got aw/w/b/r/upd=%b ar_ready=%b want 00000 1",
               {aw_ready_o, w_ready_o, b_valid_o, r_valid_o, cfg_update_o}, ar_ready_o);
    end
    tests++;
    if ({b_resp_o, r_resp_o, r_data_o, cfg_update_idx_o} !== '0 || entry_first_o !== '0 ||
        entry_last_o !== '0 || entry_base_o !== '0 || entry_valid_o !== '0 ||
        entry_ro_o !== '0) begin
      fails++;
      $display("FAIL reset_data: got r_data=%h b_resp=%b r_resp=%b valid=%b want all zero",
               r_data_o, b_resp_o, r_resp_o, entry_valid_o);
    end
    do_read(32'h18, d1, d2, rs, rv, tmo);
    tests++;
    if (tmo !== 0 || rv !== 1 || d1 !== 32'h0 || rs !== 2'b00) begin
      fails++;
      $display("FAIL reset_read: got tmo=%b rv=%b data=%h resp=%b want 0 1 0 00",
               tmo, rv, d1, rs);
    end
  endtask

  task automatic test_write_flags();
    logic [1:0] rs, er; logic bv, upd, ua, tmo; logic [IW-1:0] ui;
    do_write(32'h20, 32'h1000_0000, 4'hF, rs, bv, upd, ui, ua, tmo);
    model_write(32'h20, 32'h1000_0000, 4'hF, er);
    tests++;
    if (tmo !== 0 || bv !== 1 || rs !== 2'b00 || upd !== 0) begin
      fails++;
      $display("FAIL wr_first: got tmo=%b bv=%b resp=%b upd=%b want 0 1 00 0", tmo, bv, rs, upd);
    end
    do_write(32'h38, 32'h3, 4'hF, rs, bv, upd, ui, ua, tmo);
    model_write(32'h38, 32'h3, 4'hF, er);
    tests++;
    if (tmo !== 0 || bv !== 1 || rs !== 2'b00 || upd !== 1 || ui !== 3'd1 || ua !== 0) begin
      fails++;
      $display("FAIL wr_flags: got bv=%b resp=%b upd=%b idx=%0d upd_next=%b want 1 00 1 1 0",
               bv, rs, upd, ui, ua);
    end
    tests++;
    if (entry_first_o[127:64] !== 64'h0000_0000_1000_0000 || entry_valid_o[1] !== 1 ||
        entry_ro_o[1] !== 1) begin
      fails++;
      $display("FAIL entry1: got first=%h valid=%b ro=%b want 0000000010000000 1 1",
               entry_first_o[127:64], entry_valid_o[1], entry_ro_o[1]);
    end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] rs, er; logic bv, upd, ua, tmo; logic [IW-1:0] ui;
    apply_reset();
    do_write(32'h04, 32'hAABB_CCDD, 4'h5, rs, bv, upd, ui, ua, tmo);
    model_write(32'h04, 32'hAABB_CCDD, 4'h5, er);
    tests++;
    if (tmo !== 0 || entry_first_o[63:32] !== 32'h00BB_00DD || rs !== er) begin
      fails++;
      $display("FAIL partial_strb: got first_hi=%h resp=%b want 00bb00dd %b",
               entry_first_o[63:32], rs, er);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] rs, er; logic bv, upd, ua, tmo, rv; logic [IW-1:0] ui;
    logic [31:0] d1, d2;
    do_write(32'h100, 32'hFFFF_FFFF, 4'hF, rs, bv, upd, ui, ua, tmo);
    model_write(32'h100, 32'hFFFF_FFFF, 4'hF, er);
    tests++;
    if (tmo !== 0 || bv !== 1 || rs !== 2'b10 || entry_first_o !== exp_pair(0)) begin
      fails++;
      $display("FAIL oor_write: got bv=%b resp=%b first_changed=%b want 1 10 0",
               bv, rs, entry_first_o !== exp_pair(0));
    end
    do_write(32'h118, 32'h3, 4'hF, rs, bv, upd, ui, ua, tmo);
    model_write(32'h118, 32'h3, 4'hF, er);
    tests++;
    if (rs !== 2'b10 || upd !== 0 || entry_valid_o !== exp_flag(0)) begin
      fails++;
      $display("FAIL oor_flags: got resp=%b upd=%b valid=%b want 10 0 %b",
               rs, upd, entry_valid_o, exp_flag(0));
    end
    do_read(32'h104, d1, d2, rs, rv, tmo);
    tests++;
    if (tmo !== 0 || rv !== 1 || d1 !== 32'h0 || rs !== 2'b10) begin
      fails++;
      $display("FAIL oor_read: got rv=%b data=%h resp=%b want 1 0 10", rv, d1, rs);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] er; int stuck = 0;
    b_ready_i = 0;
    aw_addr_i = 32'h30; w_data_i = 32'h1234_5678; w_strb_i = 4'hF;
    aw_valid_i = 1; w_valid_i = 1;
    #1; @(posedge clk); #1;
    model_write(32'h30, 32'h1234_5678, 4'hF, er);
    aw_addr_i = 32'h34; w_data_i = 32'h9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (aw_ready_o !== 0 || w_ready_o !== 0) stuck++;
      @(posedge clk); #1;
    end
    tests++;
    if (stuck != 0 || b_valid_o !== 1) begin
      fails++;
      $display("FAIL bp_hold: got ready_high_cycles=%0d b_valid=%b want 0 1", stuck, b_valid_o);
    end
    b_ready_i = 1;
    #1;
    tests++;
    if (aw_ready_o !== 1 || w_ready_o !== 1) begin
      fails++;
      $display("FAIL bp_release: got aw_ready=%b w_ready=%b want 1 1", aw_ready_o, w_ready_o);
    end
    @(posedge clk); #1;
    aw_valid_i = 0; w_valid_i = 0;
    model_write(32'h34, 32'h9ABC_DEF0, 4'hF, er);
    tests++;
    if (b_valid_o !== 1 || entry_base_o !== exp_pair(4)) begin
      fails++;
      $display("FAIL bp_second: got b_valid=%b base0=%h want 1 %h",
               b_valid_o, entry_base_o[63:0], {m_w[0][5], m_w[0][4]});
    end
    @(posedge clk); #1;
    b_ready_i = 0;
    // AW alone must never be taken.
    stuck = 0;
    aw_addr_i = 32'h30; w_data_i = 32'hDEAD_BEEF; aw_valid_i = 1; w_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (aw_ready_o !== 0) stuck++;
      @(posedge clk); #1;
    end
    aw_valid_i = 0;
    tests++;
    if (stuck != 0 || b_valid_o !== 0 || entry_base_o !== exp_pair(4)) begin
      fails++;
      $display("FAIL lone_aw: got accepted_cycles=%0d b_valid=%b want 0 0", stuck, b_valid_o);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] rs, er; logic bv, upd, ua, tmo, rv; logic [IW-1:0] ui;
    logic [31:0] d1, d2, rd;
    do_write(32'h10, 32'h11, 4'hF, rs, bv, upd, ui, ua, tmo);
    model_write(32'h10, 32'h11, 4'hF, er);
    b_ready_i = 0; r_ready_i = 0;
    aw_addr_i = 32'h10; w_data_i = 32'h22; w_strb_i = 4'hF; aw_valid_i = 1; w_valid_i = 1;
    ar_addr_i = 32'h10; ar_valid_i = 1;
    #1; @(posedge clk); #1;
    aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0;
    rd = r_data_o;
    model_write(32'h10, 32'h22, 4'hF, er);
    b_ready_i = 1; r_ready_i = 1;
    @(posedge clk); #1;
    b_ready_i = 0; r_ready_i = 0;
    tests++;
    if (rd !== 32'h11) begin
      fails++;
      $display("FAIL same_cycle_old: got %h want 00000011", rd);
    end
    do_read(32'h10, d1, d2, rs, rv, tmo);
    tests++;
    if (d1 !== 32'h22 || rs !== 2'b00) begin
      fails++;
      $display("FAIL same_cycle_new: got %h resp=%b want 00000022 00", d1, rs);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] er; int bad_w = 0; int bad_r = 0;
    logic [31:0] a, d;
    b_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 32 + 8); d = $urandom();
      aw_addr_i = a; w_data_i = d; w_strb_i = 4'hF; aw_valid_i = 1; w_valid_i = 1;
      #1;
      if (aw_ready_o !== 1) bad_w++;
      model_write(a, d, 4'hF, er);
      @(posedge clk); #1;
      if (b_valid_o !== 1 || b_resp_o !== 2'b00) bad_w++;
    end
    aw_valid_i = 0; w_valid_i = 0;
    tests++;
    if (bad_w != 0 || entry_last_o !== exp_pair(2)) begin
      fails++;
      $display("FAIL b2b_write: got stalls=%0d last0=%h want 0 %h",
               bad_w, entry_last_o[63:0], {m_w[0][3], m_w[0][2]});
    end
    @(posedge clk); #1;
    b_ready_i = 0;
    r_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 32 + 8);
      ar_addr_i = a; ar_valid_i = 1;
      #1;
      if (ar_ready_o !== 1) bad_r++;
      @(posedge clk); #1;
      if (r_valid_o !== 1 || r_data_o !== model_read(a)) bad_r++;
    end
    ar_valid_i = 0;
    @(posedge clk); #1;
    r_ready_i = 0;
    tests++;
    if (bad_r != 0) begin
      fails++;
      $display("FAIL b2b_read: got %0d bad beats want 0", bad_r);
    end
  endtask

  task automatic test_random();
    logic [1:0] rs, er; logic bv, upd, ua, tmo, rv; logic [IW-1:0] ui;
    logic [31:0] a, d, r, d1, d2; logic [3:0] s; int idx, wd;
    for (int n = 0; n < 80; n++) begin
      r = $urandom(); d = $urandom(); s = 4'($urandom_range(0, 15));
      idx = $urandom_range(0, NB + 1); wd = $urandom_range(0, 7);
      a = {r[31:20], 15'(idx), 3'(wd), r[1:0]};
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, d, s, rs, bv, upd, ui, ua, tmo);
        model_write(a, d, s, er);
        tests++;
        if (tmo !== 0 || bv !== 1 || rs !== er || upd !== (idx < NB && wd == 6) ||
            (upd === 1 && ui !== 3'(idx))) begin
          fails++;
          $display("FAIL rnd_wr a=%h: got bv=%b resp=%b upd=%b idx=%0d want 1 %b %b %0d",
                   a, bv, rs, upd, ui, er, (idx < NB && wd == 6), idx);
        end
        tests++;
        if (entry_first_o !== exp_pair(0) || entry_last_o !== exp_pair(2) ||
            entry_base_o !== exp_pair(4) || entry_valid_o !== exp_flag(0) ||
            entry_ro_o !== exp_flag(1)) begin
          fails++;
          $display("FAIL rnd_entries a=%h d=%h s=%h: valid=%b ro=%b want %b %b",
                   a, d, s, entry_valid_o, entry_ro_o, exp_flag(0), exp_flag(1));
        end
      end else begin
        do_read(a, d1, d2, rs, rv, tmo);
        tests++;
        if (tmo !== 0 || rv !== 1 || d1 !== model_read(a) || d2 !== d1 ||
            rs !== model_resp(a)) begin
          fails++;
          $display("FAIL rnd_rd a=%h: got rv=%b data=%h/%h resp=%b want 1 %h %b",
                   a, rv, d1, d2, rs, model_read(a), model_resp(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    b_ready_i = 0;
    aw_addr_i = 32'h38; w_data_i = 32'h1; w_strb_i = 4'hF; aw_valid_i = 1; w_valid_i = 1;
    ar_addr_i = 32'h0; ar_valid_i = 1; r_ready_i = 0;
    #1; @(posedge clk); #1;
    aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0;
    rst_i = 1;
    @(posedge clk); #1;
    tests++;
    if (b_valid_o !== 0 || r_valid_o !== 0 || cfg_update_o !== 0 || entry_valid_o !== '0 ||
        entry_first_o !== '0 || ar_ready_o !== 1) begin
      fails++;
      $display("FAIL mid_reset: got b_valid=%b r_valid=%b upd=%b valid=%b want 0 0 0 0",
               b_valid_o, r_valid_o, cfg_update_o, entry_valid_o);
    end
    rst_i = 0;
    model_reset();
  endtask

  initial begin
    rst_i = 1;
    test_reset();
    test_write_flags();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
